ex_muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit in the EX stage, beside the single-cycle ALU.

---
 rtl/ex_muldiv_pkg.sv | 17 +
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv_unit_sign_fix.sv | 45 ++++
 rtl/ex_muldiv_unit.sv | 122 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div unit.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            start_ex;
    logic            flush_ex;
    logic [2:0]      func3_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [XLEN-1:0] result_ex;
    logic            done_ex;
    logic            busy_ex;
    logic            stall_ex;

    modport master (
        output start_ex, flush_ex, func3_ex, rs1_data_ex, rs2_data_ex,
        input  result_ex, done_ex, busy_ex, stall_ex
    );

    modport slave (
        input  start_ex, flush_ex, func3_ex, rs1_data_ex, rs2_data_ex,
        output result_ex, done_ex, busy_ex, stall_ex
    );
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes at entry, result sign correction at exit.
module muldiv_sign_fix
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              sign_a,
    output logic              sign_b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    input  logic [2:0]        fix_func3,
    input  logic              fix_sign_a,
    input  logic              fix_sign_b,
    input  logic [2*XLEN-1:0] raw,
    output logic [XLEN-1:0]   fixed
);
    logic              signed_a, signed_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    assign signed_a = !(func3 == F3_MULHU || func3 == F3_DIVU || func3 == F3_REMU);
    assign signed_b = (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
    assign sign_a   = signed_a && rs1[XLEN-1];
    assign sign_b   = signed_b && rs2[XLEN-1];
    assign mag_a    = sign_a ? -rs1 : rs1;
    assign mag_b    = sign_b ? -rs2 : rs2;

    // raw holds the product, or {remainder, quotient} for divides
    assign prod = (fix_sign_a ^ fix_sign_b) ? -raw : raw;
    assign quot = raw[XLEN-1:0];
    assign rem  = raw[2*XLEN-1:XLEN];

    always_comb begin
        fixed = '0;
        case (fix_func3)
            F3_MUL:                       fixed = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fixed = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fixed = (fix_sign_a ^ fix_sign_b) ? -quot : quot;
            default:                      fixed = fix_sign_a ? -rem : rem;
        endcase
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Bit-serial RV32M/RV64M multiply/divide unit for the EX stage.
// state | meaning
// IDLE  | waiting for start_ex
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result_ex valid, done_ex high for one cycle
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_next;
    logic [CNT_W-1:0]  counter;
    logic [2*XLEN-1:0] acc, acc_next;
    logic [XLEN-1:0]   op_mag, result_q, early_result, fixed_result, mag_a, mag_b;
    logic [2:0]        f3_q;
    logic              sign_a_q, sign_b_q, sign_a, sign_b;
    logic              accept, early, div_zero, div_ovf, div_ge, done_q;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .func3      (bus.func3_ex),
        .rs1        (bus.rs1_data_ex),
        .rs2        (bus.rs2_data_ex),
        .sign_a     (sign_a),
        .sign_b     (sign_b),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .fix_func3  (f3_q),
        .fix_sign_a (sign_a_q),
        .fix_sign_b (sign_b_q),
        .raw        (acc_next),
        .fixed      (fixed_result)
    );

    assign accept   = (state == IDLE) && bus.start_ex && !bus.flush_ex;
    assign div_zero = (bus.rs2_data_ex == '0);
    assign div_ovf  = !bus.func3_ex[0] && (bus.rs1_data_ex == MOST_NEG) && (bus.rs2_data_ex == '1);
    assign early    = bus.func3_ex[2] && (div_zero || div_ovf);

    always_comb begin
        early_result = '0;
        if (div_zero)
            early_result = bus.func3_ex[1] ? bus.rs1_data_ex : '1;
        else
            early_result = bus.func3_ex[1] ? '0 : bus.rs1_data_ex;
    end

    // acc = {high half, low half}: multiplier shifts out of the low half while
    // the product fills in; for divides it is {partial remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_mag} : '0);
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, op_mag};
    assign div_ge    = !div_diff[XLEN];

    always_comb begin
        acc_next = '0;
        if (state == MUL)
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else
            acc_next = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = early ? DONE : (bus.func3_ex[2] ? DIV : MUL);
            MUL,
            DIV:  if (counter == CNT_W'(1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush_ex)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            acc      <= '0;
            op_mag   <= '0;
            f3_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state != DONE) && (state_next == DONE);
            if (accept) begin
                f3_q     <= bus.func3_ex;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                counter  <= CNT_W'(XLEN);
                if (early) begin
                    result_q <= early_result;
                end else begin
                    acc    <= {{XLEN{1'b0}}, (bus.func3_ex[2] ? mag_a : mag_b)};
                    op_mag <= bus.func3_ex[2] ? mag_b : mag_a;
                end
            end else if ((state == MUL || state == DIV) && !bus.flush_ex) begin
                acc     <= acc_next;
                counter <= counter - CNT_W'(1);
                if (counter == CNT_W'(1))
                    result_q <= fixed_result;
            end
        end
    end

    assign bus.result_ex = result_q;
    assign bus.done_ex   = done_q;
    assign bus.busy_ex   = (state != IDLE);
    assign bus.stall_ex  = accept || (state == MUL) || (state == DIV);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and random checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

    localparam int XL = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_if #(.XLEN(XL)) bus();

    ex_muldiv_unit #(.XLEN(XL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p, ua, ub;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got);
        logic [31:0] expv;
        bit          early, seen;
        int          lat, stall_n;
        expv    = ref_model(f3, a, b);
        early   = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        seen    = 0;
        lat     = 0;
        stall_n = 0;
        got     = '0;
        @(negedge clk);
        bus.func3_ex    = f3;
        bus.rs1_data_ex = a;
        bus.rs2_data_ex = b;
        bus.start_ex    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            #1;
            bus.start_ex = 1'b0;
            if (bus.done_ex) begin
                seen = 1;
                break;
            end
            if (bus.stall_ex) stall_n++;
        end
        got = bus.result_ex;
        chk($sformatf("done_seen f3=%0d", f3), 64'(seen), 64'd1);
        chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), 64'(got), 64'(expv));
        chk($sformatf("latency f3=%0d", f3), 64'(lat), early ? 64'd1 : 64'(XL + 1));
        chk($sformatf("stall_cycles f3=%0d", f3), 64'(stall_n), early ? 64'd0 : 64'(XL));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(bus.done_ex), 64'd0);
        chk("idle_after_done", 64'(bus.busy_ex), 64'd0);
    endtask

    initial begin
        logic [31:0] got, a, b;
        logic [2:0]  f3;
        int          dn, sel;

        bus.start_ex    = 1'b0;
        bus.flush_ex    = 1'b0;
        bus.func3_ex    = '0;
        bus.rs1_data_ex = '0;
        bus.rs2_data_ex = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 64'(bus.result_ex), 64'd0);
        chk("reset_done",   64'(bus.done_ex),   64'd0);
        chk("reset_busy",   64'(bus.busy_ex),   64'd0);
        chk("reset_stall",  64'(bus.stall_ex),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, got);
        chk("mul_7x-3", 64'(got), 64'hFFFF_FFEB);
        run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, got);
        chk("mulhu_max", 64'(got), 64'hFFFF_FFFE);
        run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, got);
        chk("mulh_m1", 64'(got), 64'h0);
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, got);
        chk("mulhsu_m1x2", 64'(got), 64'hFFFF_FFFF);
        run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, got);
        chk("div_-7/2", 64'(got), 64'hFFFF_FFFD);
        run_op(F3_REM,  32'hFFFF_FFF9, 32'd2, got);
        chk("rem_-7/2", 64'(got), 64'hFFFF_FFFF);
        run_op(F3_DIVU, 32'd100, 32'd7, got);
        chk("divu_100/7", 64'(got), 64'd14);
        run_op(F3_REMU, 32'd100, 32'd7, got);
        chk("remu_100/7", 64'(got), 64'd2);
        run_op(F3_DIV,  32'd5, 32'd0, got);
        chk("div_by_zero", 64'(got), 64'hFFFF_FFFF);
        run_op(F3_REM,  32'd5, 32'd0, got);
        chk("rem_by_zero", 64'(got), 64'd5);
        run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, got);
        chk("div_overflow", 64'(got), 64'h8000_0000);
        run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, got);
        chk("rem_overflow", 64'(got), 64'd0);

        // start and flush together in IDLE: not accepted
        @(negedge clk);
        bus.func3_ex = F3_MUL;
        bus.start_ex = 1'b1;
        bus.flush_ex = 1'b1;
        #1;
        chk("start_flush_stall", 64'(bus.stall_ex), 64'd0);
        @(posedge clk);
        #1;
        chk("start_flush_busy", 64'(bus.busy_ex), 64'd0);
        bus.start_ex = 1'b0;
        bus.flush_ex = 1'b0;
        @(posedge clk);
        #1;
        chk("start_flush_done", 64'(bus.done_ex), 64'd0);

        // flush in the middle of a multiply
        @(negedge clk);
        bus.func3_ex    = F3_MUL;
        bus.rs1_data_ex = 32'd123;
        bus.rs2_data_ex = 32'd456;
        bus.start_ex    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_ex = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_ex = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_ex = 1'b0;
        chk("flush_busy", 64'(bus.busy_ex), 64'd0);
        chk("flush_done", 64'(bus.done_ex), 64'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done_ex) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        run_op(F3_DIV, 32'd9, 32'd3, got);
        chk("div_9/3_after_flush", 64'(got), 64'd3);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.func3_ex    = F3_DIV;
        bus.rs1_data_ex = 32'd1000;
        bus.rs2_data_ex = 32'd3;
        bus.start_ex    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_ex = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_result", 64'(bus.result_ex), 64'd0);
        chk("rst_mid_done",   64'(bus.done_ex),   64'd0);
        chk("rst_mid_busy",   64'(bus.busy_ex),   64'd0);
        chk("rst_mid_stall",  64'(bus.stall_ex),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(F3_MUL, 32'd6, 32'd7, got);
        chk("mul_6x7_after_rst", 64'(got), 64'd42);

        // random operations, biased toward division corner cases
        for (int n = 0; n < 40; n++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) a = 32'($urandom_range(0, 100));
            run_op(f3, a, b, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
